// File: rtl/verificador_lfsr_pkg.sv
// rtl/verificador_lfsr_pkg.sv - shared LFSR step, tap constant and checker states
// Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, same as the random generator.
package verificador_lfsr_pkg;

  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic {BUSCA, TRAVADO} estado_t;

  function automatic logic [15:0] proximo(input logic [15:0] s);
    return {s[14:0], ^(s & TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_proximo.sv
// rtl/lfsr_proximo.sv - combinational next-word step of the 16-bit random LFSR
// Shared with the generator bench model so both sides step the sequence identically.
module lfsr_proximo
  import verificador_lfsr_pkg::*;
(
  input  logic [15:0] semente,
  output logic [15:0] seguinte
);

  assign seguinte = proximo(semente);

endmodule

// File: rtl/verificador_lfsr.sv
// rtl/verificador_lfsr.sv - locks onto the random LFSR stream and flags mispredicted words
// Relock after MAX_MISS consecutive misses is enabled by VERIFICADOR_LFSR_RELOCK_EN.
module verificador_lfsr
  import verificador_lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_MISS   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valido,
  input  logic [15:0] dado,
  output logic        travado,
  output logic        erro,
  output logic [7:0]  contagem_erros,
  output logic [15:0] esperado
);

  if (LOCK_COUNT == 0 || LOCK_COUNT > 15 || MAX_MISS == 0 || MAX_MISS > 15) begin : g_faixa
    $error("verificador_lfsr: LOCK_COUNT and MAX_MISS must be in 1..15");
  end

  localparam logic [3:0] LIMITE_ACERTOS = 4'(LOCK_COUNT);

  estado_t     estado, estado_prox;
  logic [15:0] ultimo, ultimo_prox;
  logic [15:0] esperado_prox;
  logic [15:0] predito;
  logic [3:0]  acertos, acertos_prox;
  logic        erro_prox;
  logic [7:0]  contagem_prox;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
  localparam logic [3:0] LIMITE_FALHAS = 4'(MAX_MISS);
  logic [3:0]  falhas, falhas_prox;
`endif

  assign predito = proximo(ultimo);

  // esperado tracks next(ultimo) one register stage ahead so it is valid straight from the flop
  lfsr_proximo u_proximo (
    .semente  (ultimo_prox),
    .seguinte (esperado_prox)
  );

  always_comb begin
    estado_prox   = estado;
    ultimo_prox   = ultimo;
    acertos_prox  = acertos;
    erro_prox     = 1'b0;
    contagem_prox = contagem_erros;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
    falhas_prox   = falhas;
`endif
    if (valido) begin
      case (estado)
        BUSCA: begin
          ultimo_prox = dado;
          // zero is the lock-up word and must never build confidence
          if (dado == predito && dado != 16'h0000) begin
            if (acertos + 4'd1 == LIMITE_ACERTOS) begin
              estado_prox  = TRAVADO;
              acertos_prox = 4'd0;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
              falhas_prox  = 4'd0;
`endif
            end else begin
              acertos_prox = acertos + 4'd1;
            end
          end else begin
            acertos_prox = 4'd0;
          end
        end
        TRAVADO: begin
          // flywheel: the prediction advances regardless of what arrived
          ultimo_prox = predito;
          if (dado == predito) begin
`ifdef VERIFICADOR_LFSR_RELOCK_EN
            falhas_prox = 4'd0;
`endif
          end else begin
            erro_prox = 1'b1;
            if (contagem_erros != 8'hFF) contagem_prox = contagem_erros + 8'd1;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
            if (falhas + 4'd1 == LIMITE_FALHAS) begin
              estado_prox  = BUSCA;
              acertos_prox = 4'd0;
              falhas_prox  = 4'd0;
              ultimo_prox  = dado;
            end else begin
              falhas_prox  = falhas + 4'd1;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= BUSCA;
      ultimo         <= 16'h0000;
      esperado       <= 16'h0001;
      acertos        <= 4'd0;
      erro           <= 1'b0;
      contagem_erros <= 8'd0;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
      falhas         <= 4'd0;
`endif
    end else begin
      estado         <= estado_prox;
      ultimo         <= ultimo_prox;
      esperado       <= esperado_prox;
      acertos        <= acertos_prox;
      erro           <= erro_prox;
      contagem_erros <= contagem_prox;
`ifdef VERIFICADOR_LFSR_RELOCK_EN
      falhas         <= falhas_prox;
`endif
    end
  end

  assign travado = (estado == TRAVADO);

endmodule

// File: tb/tb_verificador_lfsr.sv
// tb/tb_verificador_lfsr.sv - directed self-checking bench for verificador_lfsr
// Expectations follow VERIFICADOR_LFSR_RELOCK_EN when the relock build is selected.
module tb_verificador_lfsr;

  logic        clock = 1'b0;
  logic        reset;
  logic        valido;
  logic [15:0] dado;
  logic        travado;
  logic        erro;
  logic [7:0]  contagem_erros;
  logic [15:0] esperado;

  int          erros  = 0;
  int          checks = 0;
  logic [15:0] cur;
  logic [15:0] inicio [5];

  always #5 clock = ~clock;

  verificador_lfsr #(.LOCK_COUNT(4), .MAX_MISS(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .valido         (valido),
    .dado           (dado),
    .travado        (travado),
    .erro           (erro),
    .contagem_erros (contagem_erros),
    .esperado       (esperado)
  );

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic verifica(input string tag, input logic [15:0] obtido, input logic [15:0] alvo);
    checks++;
    if (obtido !== alvo) begin
      erros++;
      $display("FAIL %s: got %h expected %h", tag, obtido, alvo);
    end
  endtask

  task automatic amostra(input logic v, input logic [15:0] d);
    valido = v;
    dado   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic confere_reset(input string tag);
    verifica({tag, "_travado"}, 16'(travado), 16'h0000);
    verifica({tag, "_erro"}, 16'(erro), 16'h0000);
    verifica({tag, "_contagem"}, 16'(contagem_erros), 16'h0000);
    verifica({tag, "_esperado"}, esperado, 16'h0001);
  endtask

  initial begin
    inicio[0] = 16'hACE1;
    inicio[1] = 16'h59C3;
    inicio[2] = 16'hB387;
    inicio[3] = 16'h670F;
    inicio[4] = 16'hCE1E;

    reset  = 1'b1;
    valido = 1'b0;
    dado   = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    confere_reset("reset_inicial");
    reset = 1'b0;

    // clean lock on the hand-computed sequence
    for (int i = 0; i < 5; i++) begin
      amostra(1'b1, inicio[i]);
      if (i == 0) verifica("semente_esperado", esperado, 16'h59C3);
      if (i == 3) verifica("ainda_buscando", 16'(travado), 16'h0000);
    end
    verifica("travou", 16'(travado), 16'h0001);
    verifica("esperado_travado", esperado, 16'h9C3C);
    cur = 16'hCE1E;

    // single corruption with the lock-up word
    amostra(1'b1, 16'h0000);
    cur = lfsr_ref(cur);
    verifica("corrupcao_erro", 16'(erro), 16'h0001);
    verifica("corrupcao_contagem", 16'(contagem_erros), 16'h0001);
    verifica("corrupcao_travado", 16'(travado), 16'h0001);
    amostra(1'b1, lfsr_ref(cur));
    cur = lfsr_ref(cur);
    verifica("pos_corrupcao_erro", 16'(erro), 16'h0000);
    verifica("pos_corrupcao_contagem", 16'(contagem_erros), 16'h0001);
    verifica("pos_corrupcao_travado", 16'(travado), 16'h0001);

    // stall: garbage on dado must not move anything
    for (int i = 0; i < 7; i++) begin
      amostra(1'b0, 16'($urandom));
      verifica("pausa_erro", 16'(erro), 16'h0000);
      verifica("pausa_esperado", esperado, lfsr_ref(cur));
    end
    for (int i = 0; i < 2; i++) begin
      amostra(1'b1, lfsr_ref(cur));
      cur = lfsr_ref(cur);
      verifica("retomada_erro", 16'(erro), 16'h0000);
    end
    verifica("retomada_travado", 16'(travado), 16'h0001);

    // asynchronous reset between edges while erro is high
    amostra(1'b1, lfsr_ref(cur) ^ 16'h0100);
    verifica("antes_reset_erro", 16'(erro), 16'h0001);
    verifica("antes_reset_contagem", 16'(contagem_erros), 16'h0002);
    #2 reset = 1'b1;
    #1;
    confere_reset("reset_assincrono");
    valido = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // relock scenario: lock again, then three consecutive misses
    for (int i = 0; i < 5; i++) amostra(1'b1, inicio[i]);
    verifica("relock_travou", 16'(travado), 16'h0001);
    cur = 16'hCE1E;
    for (int i = 0; i < 3; i++) begin
      amostra(1'b1, lfsr_ref(cur) ^ 16'h8000);
      cur = lfsr_ref(cur);
      verifica("falha_erro", 16'(erro), 16'h0001);
    end
    verifica("falhas_contagem", 16'(contagem_erros), 16'h0003);
`ifdef VERIFICADOR_LFSR_RELOCK_EN
    verifica("falhas_destrava", 16'(travado), 16'h0000);
    cur = 16'h1234;
    amostra(1'b1, cur);
    for (int i = 0; i < 4; i++) begin
      cur = lfsr_ref(cur);
      amostra(1'b1, cur);
    end
    verifica("retravou", 16'(travado), 16'h0001);
    verifica("retravou_esperado", esperado, lfsr_ref(cur));
    verifica("retravou_contagem", 16'(contagem_erros), 16'h0003);
`else
    verifica("falhas_absorvente", 16'(travado), 16'h0001);
`endif

    // saturation: pairs of misses separated by a good word keep lock in both builds
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 2; k++) begin
        amostra(1'b1, lfsr_ref(cur) ^ 16'h00FF);
        cur = lfsr_ref(cur);
        verifica("saturacao_erro", 16'(erro), 16'h0001);
      end
      amostra(1'b1, lfsr_ref(cur));
      cur = lfsr_ref(cur);
      verifica("saturacao_ok", 16'(erro), 16'h0000);
    end
    verifica("saturacao_contagem", 16'(contagem_erros), 16'h00FF);
    verifica("saturacao_travado", 16'(travado), 16'h0001);

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule

// File: doc/verificador_lfsr.md
# verificador_lfsr

Sequence checker for the 16-bit `random` LFSR generator. It consumes the generator's output words and acquires lock on the sequence. After locking it predicts every following word and flags and counts mismatches. It sits at the receiving end of the random-number path and serves as the self-test for generator output in the project and in bench runs.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct transitions needed to lock (1..15).
- `MAX_MISS`, default 3: consecutive mismatches while locked that force a return to search (1..15; used only with the relock feature).
- `clock`  in  1: single clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `valido`  in  1: `dado` holds a sample this cycle.
- `dado`  in  16: generator word.
- `travado`  out  1: checker is locked to the sequence.
- `erro`  out  1: one-cycle pulse on a mismatch while locked.
- `contagem_erros`  out  8: total mismatches since reset; saturates at 255.
- `esperado`  out  16: word predicted for the next valid sample (valid while `travado`=1).

## Operation
- Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, matching `random`: next(s) = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
- Registers:
  - `ultimo[15:0]`: reference word.
  - `acertos[3:0]`: match counter.
  - `falhas[3:0]`: miss counter.
  - `estado`: BUSCA or TRAVADO.
  - `contagem_erros`.
- Cycles with `valido`=0 change nothing, and `erro` stays 0.
- BUSCA state, on each valid sample:
  - `dado` == next(`ultimo`) and `dado` != 0: `acertos`++.
  - Otherwise: `acertos` <= 0.
  - In both cases `ultimo` <= `dado`.
  - When the increment makes `acertos` == `LOCK_COUNT`: go to TRAVADO, clear `acertos` and `falhas`.
- TRAVADO state, on each valid sample:
  - `ultimo` <= next(`ultimo`). This is flywheel behaviour: a bad word never reseeds the prediction.
  - `dado` == next(`ultimo`): `falhas` <= 0.
  - Otherwise: `erro` pulses, `contagem_erros`++ (saturating at 255), `falhas`++.
- `esperado` = next(`ultimo`), registered; it updates together with `ultimo`.
- The zero word is the LFSR lock-up state. It never counts as a match in BUSCA. In TRAVADO it is an ordinary mismatch.
- Reset mid-operation: returns to BUSCA with all counters 0 and `ultimo`=0, including while locked or while `erro` is high.

## Timing
- Reset values of all outputs: `travado`=0, `erro`=0, `contagem_erros`=0, `esperado`=16'h0001, which is next(0).
- All outputs are registered, so a sample at edge k is reflected at edge k+1.
- Lock latency: a clean stream starting at sample 0 raises `travado` one cycle after sample number `LOCK_COUNT` (0-based). The first sample only seeds `ultimo`.
- `erro` is high for exactly one cycle per mismatching valid sample. Back-to-back mismatches produce back-to-back pulses.
- Transition to search (with relock): `travado` falls in the same cycle as the `MAX_MISS`-th `erro` pulse, and that miss is counted.
- `valido` may stall for any number of cycles; a stall does not advance the prediction.

## Configuration
- `VERIFICADOR_LFSR_RELOCK_EN` defined:
  - when `falhas` reaches `MAX_MISS`, go to BUSCA;
  - clear `acertos`;
  - `ultimo` <= `dado`, so the bad word seeds the new search.
- Not defined: TRAVADO is absorbing. The checker leaves it only via `reset`, and `falhas` is not implemented.

## Structure
- Package `verificador_lfsr_pkg`:
  - tap constant 16'hB400;
  - state enum {BUSCA, TRAVADO};
  - function `proximo(s)` implementing the step above.
- Sub-module `lfsr_proximo`: purely combinational next-state step, instantiated once. It is shared with the `random` bench model so that generator and checker cannot diverge.
- Single FSM and counters in `verificador_lfsr`, with no other hierarchy.

## Test plan
- Reset mid-run -> after `reset` pulses while locked, all outputs return to reset values that same cycle and `esperado`=16'h0001.
- Clean lock -> feed 16'hACE1, 16'h59C3, 16'hB387, then continue the sequence with `LOCK_COUNT`=4: `travado`=1 one cycle after the 5th word, and `esperado` equals the next generator word.
- Single corruption -> when locked, replace one word with 16'h0000: one `erro` pulse, `contagem_erros`=1, the next correct word gives no error, and `travado` stays 1.
- Stall -> when locked, hold `valido`=0 for 7 cycles, then resume the sequence: no `erro`, and `esperado` is unchanged during the stall.
- Relock (macro defined, `MAX_MISS`=3) -> three wrong words: three `erro` pulses, `contagem_erros`=3, `travado`=0; then 5 correct words starting at 16'h1234 relock. Macro undefined: `travado` stays 1 and `contagem_erros`=3.
- Saturation -> 300 mismatches while locked (macro undefined): `contagem_erros`=255, and `erro` still pulses on each.
